// File: rtl/bf_bus_responder.sv
// Host-side responder for the brainfuck chip pin bus: decodes the four-phase
// chip sequence into a tape-memory or console transfer and answers with op_done.
module bf_bus_responder (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] chip_out,
    output logic [11:0] chip_in,
    input  logic        run,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        halted,
    output logic        proto_err
);

    typedef enum logic [2:0] {
        PH_NONE       = 3'd0,
        PH_OPCODE     = 3'd1,
        PH_ADDR_HI    = 3'd2,
        PH_ADDR_LO    = 3'd3,
        PH_READ_WRITE = 3'd4
    } phase_e;

    typedef enum logic [2:0] {
        OP_NONE        = 3'd0,
        OP_MEM_READ    = 3'd1,
        OP_MEM_WRITE   = 3'd2,
        OP_CONSOLE_IN  = 3'd3,
        OP_CONSOLE_OUT = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        AHI,
        ALO,
        EXEC,
        XFER,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  bus_in_q, bus_in_d;
    logic        op_done_q, op_done_d;
    logic        enable_q, enable_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic        halted_q, halted_d;
    logic        proto_err_q, proto_err_d;

    logic [2:0]  phase;
    logic [7:0]  bus;
    logic        xfer_done;
    logic [7:0]  xfer_result;

    assign phase = chip_out[10:8];
    assign bus   = chip_out[7:0];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        bus_in_d    = bus_in_q;
        op_done_d   = op_done_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        in_ready_d  = 1'b0;
        out_valid_d = out_valid_q;
        proto_err_d = proto_err_q;
        enable_d    = run;
        halted_d    = chip_out[11];
        xfer_done   = 1'b0;
        xfer_result = '0;

        case (state_q)
            IDLE: begin
                if (phase == PH_OPCODE) begin
                    op_d    = bus[2:0];
                    state_d = AHI;
                end
            end

            AHI: begin
                if (phase == PH_ADDR_HI) begin
                    addr_d[14:8] = bus[6:0];
                    state_d      = ALO;
                end else if (phase == PH_OPCODE) begin
                    op_d = bus[2:0];
                end else begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            ALO: begin
                if (phase == PH_ADDR_LO) begin
                    addr_d[7:0] = bus;
                    state_d     = EXEC;
                end else if (phase == PH_ADDR_HI) begin
                    addr_d[14:8] = bus[6:0];
                end else begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            EXEC: begin
                if (phase == PH_READ_WRITE) begin
                    wdata_d = bus;
                    state_d = XFER;
                    // Backend strobes are launched here so they are registered in the first XFER cycle.
                    case (op_q)
                        OP_MEM_READ: begin
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b0;
                        end
                        OP_MEM_WRITE: begin
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b1;
                        end
                        OP_CONSOLE_OUT: out_valid_d = 1'b1;
                        default: ;
                    endcase
                end else if (phase == PH_ADDR_LO) begin
                    addr_d[7:0] = bus;
                end else begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            XFER: begin
                case (op_q)
                    OP_MEM_READ, OP_MEM_WRITE: begin
                        if (mem_ack) begin
                            mem_req_d   = 1'b0;
                            mem_we_d    = 1'b0;
                            xfer_done   = 1'b1;
                            xfer_result = (op_q == OP_MEM_READ) ? mem_rdata : '0;
                        end
                    end
                    OP_CONSOLE_IN: begin
                        // Byte is taken now; the one-cycle in_ready completes the handshake while the source still holds it.
                        if (in_valid) begin
                            in_ready_d  = 1'b1;
                            xfer_done   = 1'b1;
                            xfer_result = in_data;
                        end
                    end
                    OP_CONSOLE_OUT: begin
                        if (out_ready) begin
                            out_valid_d = 1'b0;
                            xfer_done   = 1'b1;
                        end
                    end
                    OP_NONE: xfer_done = 1'b1;
                    default: begin
                        proto_err_d = 1'b1;
                        xfer_done   = 1'b1;
                    end
                endcase
                if (xfer_done) begin
                    bus_in_d  = xfer_result;
                    op_done_d = 1'b1;
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (phase != PH_READ_WRITE) begin
                    op_done_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bus_in_q    <= '0;
            op_done_q   <= 1'b0;
            enable_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            bus_in_q    <= bus_in_d;
            op_done_q   <= op_done_d;
            enable_q    <= enable_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign chip_in   = {2'b00, enable_q, op_done_q, bus_in_q};
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = wdata_q;
    assign halted    = halted_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_bf_bus_responder.sv
// Self-checking bench for bf_bus_responder: a chip-side sequencer honouring enable,
// backend responders with programmable wait states, and a bus_in scoreboard.
module tb_bf_bus_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] chip_out;
    logic [11:0] chip_in;
    logic        run;
    logic        mem_req, mem_we, mem_ack;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        halted, proto_err;

    bf_bus_responder dut (
        .clock(clock), .reset(reset), .chip_out(chip_out), .chip_in(chip_in), .run(run),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .halted(halted), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [14:0] addr;
        logic [7:0]  wd;
        int          delay;
        logic [7:0]  bdata;
        bit          stall;
        logic [7:0]  exp_bus;
        int          exp_lat;
        bit          exp_err;
    } vec_t;

    localparam logic [2:0] PH_NONE = 3'd0, PH_OP = 3'd1, PH_AHI = 3'd2, PH_ALO = 3'd3, PH_RW = 3'd4;

    int n_vec = 0;
    int n_miss = 0;
    logic [7:0] sb[$];
    logic [7:0] last_bus = '0;
    bit stall_mode = 0;
    int stall_k = 0;
    bit [3:0] stall_pat = 4'b1001;

    int n_mem = 0, n_inr = 0, n_inhs = 0, n_ouths = 0;
    always @(posedge clock) begin
        if (mem_req && mem_ack) n_mem <= n_mem + 1;
        if (in_ready) n_inr <= n_inr + 1;
        if (in_ready && in_valid) n_inhs <= n_inhs + 1;
        if (out_valid && out_ready) n_ouths <= n_ouths + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (stall_mode) begin
            run = stall_pat[stall_k % 4];
            stall_k++;
        end else begin
            run = 1'b1;
        end
    endtask

    // Chip model: the phase advances only across an edge where enable was high.
    task automatic chip_step(input logic [2:0] ph, input logic [7:0] b);
        bit en;
        for (int i = 0; i < 32; i++) begin
            en = chip_in[9];
            tick();
            if (en) begin
                chip_out = {1'b0, ph, b};
                return;
            end
        end
        check("chip_step enable timeout", {31'd0, chip_in[9]}, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " chip_in"}, {20'd0, chip_in}, 32'd0);
        check({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
        check({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, " mem_addr"}, {17'd0, mem_addr}, 32'd0);
        check({tag, " mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, " out_data"}, {24'd0, out_data}, 32'd0);
        check({tag, " halted"}, {31'd0, halted}, 32'd0);
        check({tag, " proto_err"}, {31'd0, proto_err}, 32'd0);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int n;
        bit done;
        bit is_mem;
        int mem0, inr0, inhs0, ouths0;
        logic [7:0] exp;
        is_mem = (v.op == 3'd1) || (v.op == 3'd2);
        mem0 = n_mem; inr0 = n_inr; inhs0 = n_inhs; ouths0 = n_ouths;
        stall_mode = v.stall;
        chip_step(PH_OP, {5'b10101, v.op});
        if (v.stall) chip_step(PH_OP, {5'b01010, v.op});
        chip_step(PH_AHI, {1'b1, v.addr[14:8]});
        chip_step(PH_ALO, v.addr[7:0]);
        chip_step(PH_RW, v.wd);
        sb.push_back(v.exp_bus);
        tick();
        n = 0;
        done = 0;
        while (!done && n < 40) begin
            mem_ack = 1'b0;
            out_ready = 1'b0;
            if (n == 0) check({tag, " bus_in held"}, {24'd0, chip_in[7:0]}, {24'd0, last_bus});
            if (is_mem) begin
                check({tag, " mem_req"}, {31'd0, mem_req}, 32'd1);
                if (n == 0) begin
                    check({tag, " mem_addr"}, {17'd0, mem_addr}, {17'd0, v.addr});
                    check({tag, " mem_we"}, {31'd0, mem_we}, (v.op == 3'd2) ? 32'd1 : 32'd0);
                end
                if (v.op == 3'd2) check({tag, " mem_wdata"}, {24'd0, mem_wdata}, {24'd0, v.wd});
            end else begin
                check({tag, " no mem_req"}, {31'd0, mem_req}, 32'd0);
            end
            if (v.op == 3'd4) begin
                check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
                check({tag, " out_data"}, {24'd0, out_data}, {24'd0, v.wd});
            end
            if (n >= v.delay) begin
                if (is_mem) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.bdata;
                end
                if (v.op == 3'd3) begin
                    in_valid = 1'b1;
                    in_data = v.bdata;
                end
                if (v.op == 3'd4) out_ready = 1'b1;
            end
            tick();
            n++;
            if (chip_in[8]) done = 1;
        end
        mem_ack = 1'b0;
        out_ready = 1'b0;
        mem_rdata = '0;
        check({tag, " op_done seen"}, {31'd0, done}, 32'd1);
        check({tag, " latency"}, n, v.exp_lat);
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            exp = sb.pop_front();
            check({tag, " bus_in"}, {24'd0, chip_in[7:0]}, {24'd0, exp});
        end
        check({tag, " req dropped"}, {31'd0, mem_req}, 32'd0);
        chip_step(PH_NONE, 8'h00);
        in_valid = 1'b0;
        check({tag, " op_done during None"}, {31'd0, chip_in[8]}, 32'd1);
        tick();
        check({tag, " op_done low"}, {31'd0, chip_in[8]}, 32'd0);
        check({tag, " bus_in after"}, {24'd0, chip_in[7:0]}, {24'd0, v.exp_bus});
        check({tag, " proto_err"}, {31'd0, proto_err}, {31'd0, v.exp_err});
        check({tag, " mem handshakes"}, n_mem - mem0, is_mem ? 1 : 0);
        check({tag, " in_ready cycles"}, n_inr - inr0, (v.op == 3'd3) ? 1 : 0);
        check({tag, " in handshakes"}, n_inhs - inhs0, (v.op == 3'd3) ? 1 : 0);
        check({tag, " out handshakes"}, n_ouths - ouths0, (v.op == 3'd4) ? 1 : 0);
        last_bus = v.exp_bus;
        stall_mode = 0;
    endtask

    vec_t vecs[7];
    vec_t r;

    initial begin
        vecs[0] = '{3'd1, 15'h1234, 8'h00, 0, 8'hA5, 1'b0, 8'hA5, 1, 1'b0};
        vecs[1] = '{3'd2, 15'h7FFF, 8'h3C, 3, 8'h00, 1'b0, 8'h00, 4, 1'b0};
        vecs[2] = '{3'd3, 15'h0000, 8'h00, 5, 8'h41, 1'b0, 8'h41, 6, 1'b0};
        vecs[3] = '{3'd4, 15'h0055, 8'h0A, 2, 8'h00, 1'b0, 8'h00, 3, 1'b0};
        vecs[4] = '{3'd1, 15'h2B0C, 8'h00, 1, 8'h5E, 1'b1, 8'h5E, 2, 1'b0};
        vecs[5] = '{3'd0, 15'h0101, 8'h77, 0, 8'hEE, 1'b0, 8'h00, 1, 1'b0};
        vecs[6] = '{3'd6, 15'h0202, 8'h11, 0, 8'hEE, 1'b0, 8'h00, 1, 1'b1};

        reset = 1'b1; run = 1'b1; chip_out = '0; mem_ack = 1'b0; mem_rdata = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_zero("reset");

        chip_out = 12'h800;
        tick();
        chip_out = '0;
        check("halted set", {31'd0, halted}, 32'd1);
        tick();
        check("halted clear", {31'd0, halted}, 32'd0);

        for (int i = 0; i < 7; i++) do_txn(vecs[i], $sformatf("v%0d", i));

        // Opcode jumping straight to ReadWrite
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_bus = '0;
        check("reset clears proto_err", {31'd0, proto_err}, 32'd0);
        chip_step(PH_OP, 8'h01);
        chip_step(PH_RW, 8'h00);
        tick();
        check("jump proto_err", {31'd0, proto_err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("jump no mem_req", {31'd0, mem_req}, 32'd0);
            check("jump no op_done", {31'd0, chip_in[8]}, 32'd0);
            tick();
        end
        chip_step(PH_NONE, 8'h00);
        r = '{3'd1, 15'h0321, 8'h00, 0, 8'hC3, 1'b0, 8'hC3, 1, 1'b1};
        do_txn(r, "after_jump");

        // Reset while a memory request is outstanding
        reset = 1'b1;
        tick();
        reset = 1'b0;
        last_bus = '0;
        chip_step(PH_OP, 8'h01);
        chip_step(PH_AHI, 8'h12);
        chip_step(PH_ALO, 8'h34);
        chip_step(PH_RW, 8'h00);
        tick();
        check("abort mem_req up", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        chip_out = '0;
        tick();
        reset = 1'b0;
        check_zero("midreset");
        r = '{3'd1, 15'h0456, 8'h00, 0, 8'h99, 1'b0, 8'h99, 1, 1'b0};
        do_txn(r, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
